// File: rtl/puzzle_pkg.sv
// Shared constants for the puzzle register file: board geometry, reset and goal
// boards, and the fixed roles of the low registers.
package puzzle_pkg;

    localparam int BOARD_W = 18;
    localparam logic [BOARD_W-1:0] INIT_BOARD = 18'b001010100101011000;
    localparam logic [BOARD_W-1:0] GOAL_BOARD = 18'b001010011100101000;

    localparam int REG_BOARD = 0;
    localparam int REG_CNT   = 1;
    localparam int REG_ORD   = 2;

endpackage

// File: rtl/undo_stack.sv
// Circular LIFO of previous r0 values. A push onto a full stack overwrites the
// oldest entry, so the history always keeps the most recent DEPTH boards.
module undo_stack #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic                           pop,
    input  logic [WIDTH-1:0]               din,
    output logic [WIDTH-1:0]               dout,
    output logic [$clog2(DEPTH+1)-1:0]     level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] top_ptr;

    // wp is the next free slot; the newest entry sits just below it.
    assign top_ptr = (wp == '0) ? PTR_W'(DEPTH - 1) : wp - 1'b1;
    assign dout    = mem[top_ptr];

    // NOTE: the entry storage has no reset; level gates every read, so stale
    // contents are never observed and the array can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wp] <= din;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            level <= '0;
        end else if (push) begin
            wp <= (wp == PTR_W'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (level != LVL_W'(DEPTH)) begin
                level <= level + 1'b1;
            end
        end else if (pop && level != '0) begin
            wp    <= top_ptr;
            level <= level - 1'b1;
        end
    end

endmodule

// File: rtl/puzzle_regfile_p.sv
// Register file whose r0 holds a puzzle board: board-changing writes bump the
// move counter in r1 and are recorded so they can be undone.
module puzzle_regfile_p #(
    parameter int                         DATA_W     = 40,
    parameter int                         DEPTH      = 16,
    parameter int                         BOARD_W    = puzzle_pkg::BOARD_W,
    parameter logic [BOARD_W-1:0]         INIT_BOARD = puzzle_pkg::INIT_BOARD,
    parameter logic [BOARD_W-1:0]         GOAL_BOARD = puzzle_pkg::GOAL_BOARD,
    parameter int                         UNDO_DEPTH = 8,
    parameter bit                         BYPASS     = 1'b0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                we,
    input  logic [$clog2(DEPTH)-1:0]            dst,
    input  logic [DATA_W-1:0]                   data,
    input  logic [$clog2(DEPTH)-1:0]            src0,
    input  logic [$clog2(DEPTH)-1:0]            src1,
    input  logic                                undo,
    output logic [DATA_W-1:0]                   data0,
    output logic [DATA_W-1:0]                   data1,
    output logic [DATA_W-1:0]                   cnt,
    output logic [DATA_W-1:0]                   ord,
    output logic                                comp,
    output logic                                undo_err,
    output logic [$clog2(UNDO_DEPTH+1)-1:0]     undo_lvl
);
    import puzzle_pkg::*;

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0]  regs [DEPTH];
    logic [BOARD_W-1:0] board;
    logic [DATA_W-1:0]  top_data;
    logic               board_move;
    logic               undo_ok;
    logic               undo_rej;

    assign board      = regs[REG_BOARD][BOARD_W-1:0];
    assign board_move = we && dst == ADDR_W'(REG_BOARD) && data[BOARD_W-1:0] != board;
    assign undo_ok    = undo && !we && undo_lvl != '0;
    assign undo_rej   = undo && !undo_ok;

    undo_stack #(
        .WIDTH (DATA_W),
        .DEPTH (UNDO_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (board_move),
        .pop   (undo_ok),
        .din   (regs[REG_BOARD]),
        .dout  (top_data),
        .level (undo_lvl)
    );

    // Later assignments in this block win, so the undo/counter updates refine
    // the plain write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            regs[REG_BOARD] <= DATA_W'(INIT_BOARD);
            comp            <= 1'b0;
            undo_err        <= 1'b0;
        end else begin
            comp     <= (board == GOAL_BOARD);
            undo_err <= undo_rej;
            if (we) begin
                regs[dst] <= data;
            end
            if (board_move) begin
                regs[REG_CNT] <= regs[REG_CNT] + 1'b1;
            end
            if (undo_ok) begin
                regs[REG_BOARD] <= top_data;
                if (regs[REG_CNT] != '0) begin
                    regs[REG_CNT] <= regs[REG_CNT] - 1'b1;
                end
            end
        end
    end

    // NOTE: each output gets its default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        data0 = regs[src0];
        data1 = regs[src1];
        if (BYPASS && we && dst == src0) begin
            data0 = data;
        end
        if (BYPASS && we && dst == src1) begin
            data1 = data;
        end
    end

    assign cnt = regs[REG_CNT];
    assign ord = regs[REG_ORD];

endmodule

// File: tb/tb_puzzle_regfile_p.sv
// Bench for puzzle_regfile_p: a read-old and a write-first instance share the
// stimulus and are compared against a queue-based model of the register file.
module tb_puzzle_regfile_p;
    import puzzle_pkg::*;

    localparam int DATA_W     = 40;
    localparam int DEPTH      = 16;
    localparam int ADDR_W     = 4;
    localparam int UNDO_DEPTH = 8;
    localparam int LVL_W      = 4;
    localparam logic [DATA_W-1:0] I_B  = DATA_W'(INIT_BOARD);
    localparam logic [DATA_W-1:0] G_B  = DATA_W'(GOAL_BOARD);
    localparam logic [DATA_W-1:0] I_UP = I_B | (40'd1 << 30);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              we = 1'b0;
    logic              undo = 1'b0;
    logic [ADDR_W-1:0] dst = '0;
    logic [ADDR_W-1:0] src0 = '0;
    logic [ADDR_W-1:0] src1 = '0;
    logic [DATA_W-1:0] data = '0;

    logic [DATA_W-1:0] a_data0, a_data1, a_cnt, a_ord;
    logic [DATA_W-1:0] b_data0, b_data1, b_cnt, b_ord;
    logic              a_comp, a_err, b_comp, b_err;
    logic [LVL_W-1:0]  a_lvl, b_lvl;

    int n_cmp  = 0;
    int n_fail = 0;

    puzzle_regfile_p #(.BYPASS(1'b0)) u_old (
        .clk(clk), .rst_n(rst_n), .we(we), .dst(dst), .data(data),
        .src0(src0), .src1(src1), .undo(undo),
        .data0(a_data0), .data1(a_data1), .cnt(a_cnt), .ord(a_ord),
        .comp(a_comp), .undo_err(a_err), .undo_lvl(a_lvl)
    );

    puzzle_regfile_p #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .rst_n(rst_n), .we(we), .dst(dst), .data(data),
        .src0(src0), .src1(src1), .undo(undo),
        .data0(b_data0), .data1(b_data1), .cnt(b_cnt), .ord(b_ord),
        .comp(b_comp), .undo_err(b_err), .undo_lvl(b_lvl)
    );

    always #5 clk = ~clk;

    // Reference model: registers as an array, undo history as a queue.
    logic [DATA_W-1:0] m_r [DEPTH];
    logic [DATA_W-1:0] m_hist [$];
    logic              m_comp;
    logic              m_err;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input bit byp, input logic [ADDR_W-1:0] a);
        if (byp && we && dst == a) return data;
        return m_r[a];
    endfunction

    task automatic model_edge();
        logic [DATA_W-1:0] old0;
        logic [DATA_W-1:0] old_cnt;
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_r[i] = '0;
            m_r[0] = I_B;
            m_hist.delete();
            m_comp = 1'b0;
            m_err  = 1'b0;
        end else begin
            old0    = m_r[0];
            old_cnt = m_r[1];
            m_err   = undo && (we || m_hist.size() == 0);
            m_comp  = (old0[BOARD_W-1:0] == GOAL_BOARD);
            if (we) begin
                m_r[dst] = data;
                if (dst == 0 && data[BOARD_W-1:0] != old0[BOARD_W-1:0]) begin
                    m_hist.push_back(old0);
                    if (m_hist.size() > UNDO_DEPTH) void'(m_hist.pop_front());
                    m_r[1] = old_cnt + 1;
                end
            end else if (undo && m_hist.size() > 0) begin
                m_r[0] = m_hist.pop_back();
                m_r[1] = (old_cnt == 0) ? '0 : old_cnt - 1;
            end
        end
    endtask

    // One clock: drive, check combinational reads, take the edge, check state.
    task automatic step(input bit r, input bit w, input logic [ADDR_W-1:0] d,
                        input logic [DATA_W-1:0] v, input logic [ADDR_W-1:0] s0,
                        input logic [ADDR_W-1:0] s1, input bit u);
        @(negedge clk);
        rst_n = r; we = w; dst = d; data = v; src0 = s0; src1 = s1; undo = u;
        #1;
        check("rd0_old", a_data0, model_read(1'b0, s0));
        check("rd1_old", a_data1, model_read(1'b0, s1));
        check("rd0_byp", b_data0, model_read(1'b1, s0));
        check("rd1_byp", b_data1, model_read(1'b1, s1));
        @(posedge clk);
        model_edge();
        #1;
        check("cnt_old",  a_cnt, m_r[1]);
        check("ord_old",  a_ord, m_r[2]);
        check("lvl_old",  a_lvl, m_hist.size());
        check("err_old",  a_err, m_err);
        check("comp_old", a_comp, m_comp);
        check("post_old", a_data0, m_r[s0]);
        check("cnt_byp",  b_cnt, m_r[1]);
        check("lvl_byp",  b_lvl, m_hist.size());
        check("err_byp",  b_err, m_err);
        check("comp_byp", b_comp, m_comp);
    endtask

    typedef struct {
        bit                rst;
        bit                w;
        logic [ADDR_W-1:0] d;
        logic [DATA_W-1:0] v;
        bit                u;
        logic [ADDR_W-1:0] s0;
        logic [DATA_W-1:0] exp_d0;
        logic [DATA_W-1:0] exp_cnt;
        logic [LVL_W-1:0]  exp_lvl;
        bit                exp_err;
        bit                exp_comp;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [DATA_W-1:0] v;
        logic [ADDR_W-1:0] d;

        vt[0]  = '{1'b0, 1'b0, 4'd0, 40'd0,   1'b0, 4'd0, I_B,     40'd0, 4'd0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b1, 4'd0, G_B,     1'b0, 4'd0, G_B,     40'd1, 4'd1, 1'b0, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 4'd0, 40'd0,   1'b0, 4'd0, G_B,     40'd1, 4'd1, 1'b0, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 4'd0, 40'd0,   1'b1, 4'd0, I_B,     40'd0, 4'd0, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 4'd0, 40'd0,   1'b0, 4'd0, I_B,     40'd0, 4'd0, 1'b0, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 4'd0, 40'd0,   1'b1, 4'd0, I_B,     40'd0, 4'd0, 1'b1, 1'b0};
        vt[6]  = '{1'b1, 1'b0, 4'd0, 40'd0,   1'b0, 4'd0, I_B,     40'd0, 4'd0, 1'b0, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 4'd0, I_UP,    1'b0, 4'd0, I_UP,    40'd0, 4'd0, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b1, 4'd0, G_B,     1'b0, 4'd0, G_B,     40'd1, 4'd1, 1'b0, 1'b0};
        vt[9]  = '{1'b1, 1'b1, 4'd5, 40'd7,   1'b1, 4'd5, 40'd7,   40'd1, 4'd1, 1'b1, 1'b1};
        vt[10] = '{1'b1, 1'b0, 4'd0, 40'd0,   1'b0, 4'd0, G_B,     40'd1, 4'd1, 1'b0, 1'b1};
        vt[11] = '{1'b1, 1'b1, 4'd3, 40'hAB,  1'b0, 4'd3, 40'hAB,  40'd1, 4'd1, 1'b0, 1'b1};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        model_edge();

        for (int i = 0; i < 12; i++) begin
            step(vt[i].rst, vt[i].w, vt[i].d, vt[i].v, vt[i].s0, 4'd2, vt[i].u);
            check($sformatf("vec%0d_d0", i),   a_data0, vt[i].exp_d0);
            check($sformatf("vec%0d_cnt", i),  a_cnt,   vt[i].exp_cnt);
            check($sformatf("vec%0d_lvl", i),  a_lvl,   vt[i].exp_lvl);
            check($sformatf("vec%0d_err", i),  a_err,   vt[i].exp_err);
            check($sformatf("vec%0d_comp", i), a_comp,  vt[i].exp_comp);
        end

        // Same-cycle write-first versus read-old on an untouched register.
        @(negedge clk);
        rst_n = 1'b1; we = 1'b1; dst = 4'd7; data = 40'hCD; src0 = 4'd7; src1 = 4'd7; undo = 1'b0;
        #1;
        check("bypass_on",  b_data0, 40'hCD);
        check("bypass_off", a_data0, 40'd0);
        @(posedge clk);
        model_edge();

        // Overflow the history, unwind it fully, then underflow once.
        step(1'b0, 1'b0, 4'd0, 40'd0, 4'd0, 4'd1, 1'b0);
        for (int i = 1; i <= 9; i++) step(1'b1, 1'b1, 4'd0, DATA_W'(i), 4'd0, 4'd1, 1'b0);
        check("deep_lvl", a_lvl, 8);
        check("deep_cnt", a_cnt, 9);
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0, 4'd0, 40'd0, 4'd0, 4'd1, 1'b1);
            check($sformatf("unwind%0d", k), a_data0, 9 - k);
        end
        step(1'b1, 1'b0, 4'd0, 40'd0, 4'd0, 4'd1, 1'b1);
        check("underflow_err", a_err, 1'b1);
        check("underflow_r0",  a_data0, 40'd1);
        check("underflow_cnt", a_cnt, 40'd1);

        // Randomized traffic, including occasional mid-sequence resets.
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(4))
                0, 1:    d = 4'd0;
                2:       d = 4'd1;
                3:       d = 4'd2;
                default: d = ADDR_W'($urandom);
            endcase
            case ($urandom_range(3))
                0:       v = I_B;
                1:       v = G_B;
                2:       v = DATA_W'($urandom_range(7));
                default: v = {8'($urandom), 32'($urandom)};
            endcase
            step($urandom_range(63) != 0, $urandom_range(1) == 1, d, v,
                 ADDR_W'($urandom), ADDR_W'($urandom), $urandom_range(2) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
